// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input-conditioning blocks.
//   db_state_t  : debounce FSM state (STABLE / QUALIFY)
//   cnt_width() : width of a counter that must hold 0..db_cycles
package debounce_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } db_state_t;

    function automatic int cnt_width(input int db_cycles);
        return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_debounce_sync_chain.sv
// sync_chain: plain multi-flop synchronizer for one asynchronous level.
//   clk  in  clock
//   rst  in  asynchronous active-high reset (chain loads RST_VAL)
//   d    in  asynchronous input
//   q    out synchronized output (last stage)
// Stages are wired flop-to-flop with nothing in between so the metastability
// settling window is a full clock period per stage.
module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain_q <= {SYNC_STAGES{RST_VAL}};
        else     chain_q <= {chain_q[SYNC_STAGES-2:0], d};
    end

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: synchronize an asynchronous level and debounce it.
//   clk         in  clock, all flops posedge
//   rst         in  asynchronous active-high reset
//   din         in  raw asynchronous level
//   dout        out debounced level, direct flop output
//   busy        out high while a candidate change is being qualified
//   glitch_cnt  out saturating count of aborted qualifications
//                   (only when SYNC_DEBOUNCE_GLITCH_CNT_EN is defined)
// dout follows the synchronized input only after it has differed from dout on
// DB_CYCLES consecutive edges. Any return to the old level during
// qualification throws the partial count away.
module sync_debounce
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 16,
    parameter logic RST_VAL     = 1'b0,
    parameter int   GLITCH_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
    output logic                dout,
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    output logic [GLITCH_W-1:0] glitch_cnt,
`endif
    output logic                busy
);

    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic            sync_q;
    db_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dout_q, dout_d;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (RST_VAL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (sync_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            ST_STABLE: begin
                if (sync_q != dout_q) begin
                    // A single-cycle qualification window needs no counting.
                    if (DB_CYCLES == 1) begin
                        dout_d = sync_q;
                    end else begin
                        state_d = ST_QUALIFY;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (sync_q == dout_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    dout_d  = sync_q;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            dout_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;
    assign busy = (state_q == ST_QUALIFY);

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic                abort;
    logic [GLITCH_W-1:0] glitch_q;

    // Qualification abandoned because the input went back to the old level.
    assign abort = (state_q == ST_QUALIFY) && (sync_q == dout_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         glitch_q <= '0;
        else if (abort && ~&glitch_q)    glitch_q <= glitch_q + 1'b1;
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
module tb_sync_debounce;

    localparam int S    = 2;
    localparam int DB   = 4;
    localparam int GMAX = 15;

    logic clk, rst;
    logic din0, din1;
    logic dout0, busy0, dout1, busy1;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic [3:0] gc0, gc1;
`endif

    int errs   = 0;
    int checks = 0;

    sync_debounce #(.SYNC_STAGES(S), .DB_CYCLES(DB), .RST_VAL(1'b0), .GLITCH_W(4)) dut0 (
        .clk (clk), .rst (rst), .din (din0), .dout (dout0),
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        .glitch_cnt (gc0),
`endif
        .busy (busy0)
    );

    sync_debounce #(.SYNC_STAGES(S), .DB_CYCLES(DB), .RST_VAL(1'b1), .GLITCH_W(4)) dut1 (
        .clk (clk), .rst (rst), .din (din1), .dout (dout1),
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        .glitch_cnt (gc1),
`endif
        .busy (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the input seen by the debouncer is din delayed S edges;
    // run = number of consecutive edges that saw a level different from dout.
    typedef struct packed {
        logic [S-1:0] sh;
        logic         dout;
        logic [7:0]   run;
        logic [7:0]   gl;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mreset(input logic rv);
        mdl_t n;
        n.sh   = {S{rv}};
        n.dout = rv;
        n.run  = 8'd0;
        n.gl   = 8'd0;
        return n;
    endfunction

    function automatic mdl_t step(input mdl_t m, input logic d);
        mdl_t n;
        logic s;
        n = m;
        s = m.sh[S-1];
        if (s != m.dout) begin
            n.run = m.run + 8'd1;
            if (n.run == 8'(DB)) begin
                n.dout = s;
                n.run  = 8'd0;
            end
        end else begin
            if (m.run != 8'd0 && m.gl != 8'(GMAX)) n.gl = m.gl + 8'd1;
            n.run = 8'd0;
        end
        n.sh = {m.sh[S-2:0], d};
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= mreset(1'b0);
            m1 <= mreset(1'b1);
        end else begin
            m0 <= step(m0, din0);
            m1 <= step(m1, din1);
        end
    end

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_reset();
        din0 = 1'b0; din1 = 1'b1; rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dout0 !== 1'b0) begin errs++; $display("FAIL reset_dout0 got=%b exp=0", dout0); end
        checks++; if (busy0 !== 1'b0) begin errs++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
        checks++; if (dout1 !== 1'b1) begin errs++; $display("FAIL reset_dout1 got=%b exp=1", dout1); end
        checks++; if (busy1 !== 1'b0) begin errs++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        checks++; if (gc0 !== 4'd0) begin errs++; $display("FAIL reset_glitch got=%0d exp=0", gc0); end
`endif
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rise();
        int lat, nb;
        @(negedge clk) din0 = 1'b1;
        @(posedge clk); #1;
        checks++; if (dout0 !== 1'b0) begin errs++; $display("FAIL rise_early got=%b exp=0", dout0); end
        lat = 0; nb = 0;
        while (dout0 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (busy0 === 1'b1 && dout0 !== 1'b1) nb++;
        end
        checks++; if (lat != 5) begin errs++; $display("FAIL rise_latency got=%0d exp=5", lat); end
        checks++; if (nb != 3)  begin errs++; $display("FAIL rise_busy_cycles got=%0d exp=3", nb); end
        repeat (6) begin
            @(negedge clk);
            checks++; if (dout0 !== 1'b1 || busy0 !== 1'b0) begin
                errs++; $display("FAIL rise_hold got=%b/%b exp=1/0", dout0, busy0);
            end
        end
        din0 = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (dout0 !== 1'b0) begin errs++; $display("FAIL rise_return got=%b exp=0", dout0); end
    endtask

    task automatic test_glitch();
        int widths [2] = '{1, 3};
        do_reset();
        foreach (widths[k]) begin
            repeat (3) begin
                @(negedge clk) din0 = 1'b1;
                repeat (widths[k]) @(negedge clk);
                din0 = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    checks++; if (dout0 !== 1'b0 || busy0 !== (m0.run != 0)) begin
                        errs++; $display("FAIL glitch_w%0d got=%b/%b exp=0/%b", widths[k], dout0, busy0, m0.run != 0);
                    end
                end
            end
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        checks++; if (gc0 !== 4'd6) begin errs++; $display("FAIL glitch_count got=%0d exp=6", gc0); end
`endif
    endtask

    task automatic test_bounce();
        logic [4:0] seq;
        int lat;
        seq = 5'b10101;
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            @(negedge clk) din0 = seq[i];
            checks++; if (dout0 !== 1'b0) begin errs++; $display("FAIL bounce_toggle got=%b exp=0", dout0); end
        end
        @(posedge clk); #1;
        lat = 0;
        while (dout0 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat != 5) begin errs++; $display("FAIL bounce_latency got=%0d exp=5", lat); end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        checks++; if (gc0 !== 4'd2) begin errs++; $display("FAIL bounce_glitch got=%0d exp=2", gc0); end
`endif
        repeat (5) begin
            @(negedge clk);
            checks++; if (dout0 !== 1'b1) begin errs++; $display("FAIL bounce_hold got=%b exp=1", dout0); end
        end
        din0 = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_fall();
        int lat, nb;
        @(negedge clk) din1 = 1'b0;
        @(posedge clk); #1;
        lat = 0; nb = 0;
        while (dout1 !== 1'b0 && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (busy1 === 1'b1 && dout1 !== 1'b0) nb++;
        end
        checks++; if (lat != 5) begin errs++; $display("FAIL fall_latency got=%0d exp=5", lat); end
        checks++; if (nb != 3)  begin errs++; $display("FAIL fall_busy_cycles got=%0d exp=3", nb); end
        @(negedge clk) din1 = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (dout1 !== 1'b1) begin errs++; $display("FAIL fall_return got=%b exp=1", dout1); end
    endtask

    task automatic test_async_rst();
        int lat;
        @(negedge clk) din0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy0 !== 1'b1) begin errs++; $display("FAIL arst_pre_busy got=%b exp=1", busy0); end
        #2 rst = 1'b1;
        #1;
        checks++; if (dout0 !== 1'b0 || busy0 !== 1'b0) begin
            errs++; $display("FAIL arst_immediate got=%b/%b exp=0/0", dout0, busy0);
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        checks++; if (gc0 !== 4'd0) begin errs++; $display("FAIL arst_glitch got=%0d exp=0", gc0); end
`endif
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        while (dout0 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat != 5) begin errs++; $display("FAIL arst_latency got=%0d exp=5", lat); end
        @(negedge clk) din0 = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (20) begin
            @(negedge clk) din0 = 1'b1;
            @(negedge clk) din0 = 1'b0;
            repeat (4) @(negedge clk);
        end
        checks++; if (dout0 !== 1'b0) begin errs++; $display("FAIL sat_dout got=%b exp=0", dout0); end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        checks++; if (gc0 !== 4'd15) begin errs++; $display("FAIL sat_glitch got=%0d exp=15", gc0); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        repeat (500) begin
            @(negedge clk);
            checks++; if (dout0 !== m0.dout || busy0 !== (m0.run != 0)) begin
                errs++; $display("FAIL rand0 got=%b/%b exp=%b/%b", dout0, busy0, m0.dout, m0.run != 0);
            end
            checks++; if (dout1 !== m1.dout || busy1 !== (m1.run != 0)) begin
                errs++; $display("FAIL rand1 got=%b/%b exp=%b/%b", dout1, busy1, m1.dout, m1.run != 0);
            end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
            checks++; if (gc0 !== m0.gl[3:0] || gc1 !== m1.gl[3:0]) begin
                errs++; $display("FAIL rand_glitch got=%0d/%0d exp=%0d/%0d", gc0, gc1, m0.gl, m1.gl);
            end
`endif
            if ($urandom_range(0, 3) == 0) din0 = ~din0;
            if ($urandom_range(0, 5) == 0) din1 = ~din1;
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_bounce();
        test_fall();
        test_async_rst();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
